// File: rtl/face_reader.sv
`timescale 1ns/1ps
// Read-side scanner for the face RAM: walks every cell row-major, absorbs the
// RAM's one-cycle registered-address latency and streams cells over valid/ready.
module face_reader #(
   parameter int unsigned LINES    = 3,
   parameter int unsigned COLUMNS  = 3,
   parameter int unsigned S_DATA   = 2,
   parameter int unsigned S_LINE   = 2,
   parameter int unsigned S_COLUMN = 2
) (
   input  logic                clk,
   input  logic                clear_n,
   input  logic                start,
   output logic [S_LINE-1:0]   addr_line,
   output logic [S_COLUMN-1:0] addr_column,
   input  logic [S_DATA-1:0]   q,
   output logic [S_DATA-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic                busy,
   output logic                done
);

   localparam logic [S_LINE-1:0]   LAST_LINE   = S_LINE'(LINES - 1);
   localparam logic [S_COLUMN-1:0] LAST_COLUMN = S_COLUMN'(COLUMNS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      SEND  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t              state, state_d;
   logic [S_LINE-1:0]   addr_line_d;
   logic [S_COLUMN-1:0] addr_column_d;
   logic [S_DATA-1:0]   out_data_d;
   logic                out_valid_d;
   logic                out_last_d;
   logic                busy_d;
   logic                done_d;
   logic                at_last_c;

   assign at_last_c = (addr_line == LAST_LINE) && (addr_column == LAST_COLUMN);

   // State and every output are registered together.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state       <= IDLE;
         addr_line   <= '0;
         addr_column <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_d;
         addr_line   <= addr_line_d;
         addr_column <= addr_column_d;
         out_data    <= out_data_d;
         out_valid   <= out_valid_d;
         out_last    <= out_last_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

   // Next state and next output values; the address only moves on FETCH
   // entry and in DONE so the RAM address register is quiet during LOAD.
   always_comb begin
      state_d       = state;
      addr_line_d   = addr_line;
      addr_column_d = addr_column;
      out_data_d    = out_data;
      out_valid_d   = out_valid;
      out_last_d    = out_last;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_d       = FETCH;
               addr_line_d   = '0;
               addr_column_d = '0;
            end
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            out_data_d  = q;
            out_valid_d = 1'b1;
            out_last_d  = at_last_c;
            state_d     = SEND;
         end
         SEND: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (at_last_c) begin
                  state_d = DONE;
               end else begin
                  state_d = FETCH;
                  if (addr_column == LAST_COLUMN) begin
                     addr_column_d = '0;
                     addr_line_d   = addr_line + S_LINE'(1);
                  end else begin
                     addr_column_d = addr_column + S_COLUMN'(1);
                  end
               end
            end
         end
         DONE: begin
            state_d       = IDLE;
            addr_line_d   = '0;
            addr_column_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

endmodule

// File: tb/tb_face_reader.sv
`timescale 1ns/1ps
// Bench for face_reader: RAM model, scoreboard monitor and directed/random scans
// on a 3x3 instance plus a 2x4 instance for the column-wrap case.
module tb_face_reader;

   localparam int L = 3;
   localparam int C = 3;

   typedef struct {
      logic [1:0] data;
      bit         last;
      int         line;
      int         col;
   } cell_t;

   logic       clk, clear_n, start, out_ready;
   logic [1:0] addr_line, addr_column, q, out_data;
   logic       out_valid, out_last, busy, done;

   logic       start2;
   logic [1:0] addr_line2, addr_column2, q2, out_data2;
   logic       out_valid2, out_last2, busy2, done2;

   logic [1:0] mem  [0:3][0:3];
   logic [1:0] mem2 [0:3][0:3];

   int cyc = 0;
   int n_chk = 0, n_fail = 0;
   int mon_chk = 0, mon_fail = 0;
   bit mon_en = 0;

   cell_t sb[$];
   bit    exp_busy, exp_done, hold_v, hold_l;
   logic [1:0] hold_d;
   logic [3:0] hold_a;

   face_reader dut (
      .clk(clk), .clear_n(clear_n), .start(start),
      .addr_line(addr_line), .addr_column(addr_column), .q(q),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   face_reader #(.LINES(2), .COLUMNS(4), .S_DATA(2), .S_LINE(2), .S_COLUMN(2)) dut2 (
      .clk(clk), .clear_n(clear_n), .start(start2),
      .addr_line(addr_line2), .addr_column(addr_column2), .q(q2),
      .out_data(out_data2), .out_valid(out_valid2), .out_ready(1'b1),
      .out_last(out_last2), .busy(busy2), .done(done2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Face RAM with registered address: q follows the address one edge later.
   always @(posedge clk) begin
      q  <= mem[addr_line][addr_column];
      q2 <= mem2[addr_line2][addr_column2];
   end

   function automatic int cmp(string n, logic [31:0] a, logic [31:0] e);
      if (a !== e) begin
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
         return 1;
      end
      return 0;
   endfunction

   task automatic tchk(string n, logic [31:0] a, logic [31:0] e);
      n_chk++;
      n_fail += cmp(n, a, e);
   endtask

   task automatic mchk(string n, logic [31:0] a, logic [31:0] e);
      mon_chk++;
      mon_fail += cmp(n, a, e);
   endtask

   // Scoreboard monitor and transaction-level model for the 3x3 instance.
   always @(negedge clk) begin
      bit    hs, was_last;
      cell_t e;
      if (!clear_n) begin
         sb.delete();
         exp_busy = 1'b0;
         exp_done = 1'b0;
         hold_v   = 1'b0;
      end else if (mon_en) begin
         mchk("busy", 32'(busy), 32'(exp_busy));
         mchk("done", 32'(done), 32'(exp_done));
         if (!exp_busy) begin
            mchk("idle_valid", 32'(out_valid), 0);
            mchk("idle_addr", 32'({addr_line, addr_column}), 0);
         end
         if (hold_v) begin
            mchk("hold_valid", 32'(out_valid), 1);
            mchk("hold_data", 32'(out_data), 32'(hold_d));
            mchk("hold_last", 32'(out_last), 32'(hold_l));
            mchk("hold_addr", 32'({addr_line, addr_column}), 32'(hold_a));
         end
         hs       = out_valid && out_ready;
         was_last = 1'b0;
         if (hs) begin
            if (sb.size() == 0) begin
               mchk("unexpected_cell", 1, 0);
            end else begin
               e = sb.pop_front();
               mchk("cell_data", 32'(out_data), 32'(e.data));
               mchk("cell_last", 32'(out_last), 32'(e.last));
               mchk("cell_line", 32'(addr_line), 32'(e.line));
               mchk("cell_col", 32'(addr_column), 32'(e.col));
               was_last = e.last;
            end
         end
         if (exp_done) begin
            exp_done = 1'b0;
            exp_busy = 1'b0;
         end else if (hs && was_last) begin
            exp_done = 1'b1;
         end else if (!exp_busy && start) begin
            exp_busy = 1'b1;
            for (int l = 0; l < L; l++)
               for (int c = 0; c < C; c++)
                  sb.push_back('{mem[l][c], (l == L-1) && (c == C-1), l, c});
         end
         hold_v = out_valid && !out_ready;
         hold_d = out_data;
         hold_l = out_last;
         hold_a = {addr_line, addr_column};
      end
   end

   // One scan of the 3x3 instance; times are edges after the start edge.
   task automatic run_scan(input int stall_cell, input int stall_len, input bit rnd,
                           input bit noise, input bit abort,
                           output int t_valid, output int t_done, output int t_idle,
                           output int stalls);
      int t0, cells, left, rel;
      bit hs;
      t_valid = -1; t_done = -1; t_idle = -1; stalls = 0;
      cells = 0; left = stall_len;
      start = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      start = 1'b0;
      for (int i = 0; i < 400 && t_idle < 0; i++) begin
         @(negedge clk);
         rel = cyc - t0;
         if (out_valid && t_valid < 0) t_valid = rel;
         if (done && t_done < 0) t_done = rel;
         if (t_done >= 0 && !busy && t_idle < 0) t_idle = rel;
         if (out_valid && !out_ready) stalls++;
         if (out_valid && !out_ready && cells == stall_cell) begin
            if (abort) begin
               #2 clear_n = 1'b0;
               #1;
               tchk("rst_valid", 32'(out_valid), 0);
               tchk("rst_data", 32'(out_data), 0);
               tchk("rst_last", 32'(out_last), 0);
               tchk("rst_busy", 32'(busy), 0);
               tchk("rst_done", 32'(done), 0);
               tchk("rst_addr", 32'({addr_line, addr_column}), 0);
               @(negedge clk);
               @(posedge clk); #1;
               clear_n   = 1'b1;
               out_ready = 1'b1;
               start     = 1'b0;
               break;
            end
            left--;
         end
         hs = out_valid && out_ready;
         @(posedge clk); #1;
         if (hs) cells++;
         start     = noise && ((cyc - t0 == 5) || (cyc - t0 == 14));
         out_ready = (cells == stall_cell && left > 0) ? 1'b0
                   : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      end
      if (!abort) tchk("scan_complete", 32'(t_idle >= 0), 1);
   endtask

   task automatic scan2();
      int t0, k, td;
      start2 = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      start2 = 1'b0;
      k = 0; td = -1;
      for (int i = 0; i < 100 && td < 0; i++) begin
         @(negedge clk);
         if (out_valid2) begin
            tchk("m2_data", 32'(out_data2), 32'(mem2[k / 4][k % 4]));
            tchk("m2_last", 32'(out_last2), 32'(k == 7));
            tchk("m2_addr", 32'({addr_line2, addr_column2}), 32'((k / 4) * 4 + (k % 4)));
            k++;
         end
         if (done2) td = cyc - t0;
      end
      tchk("m2_cells", 32'(k), 8);
      tchk("m2_done_time", 32'(td), 24);
   endtask

   task automatic fill_pattern();
      for (int l = 0; l < 4; l++)
         for (int c = 0; c < 4; c++)
            mem[l][c] = 2'((l * C + c) % 4);
   endtask

   task automatic fill_random();
      for (int l = 0; l < 4; l++)
         for (int c = 0; c < 4; c++)
            mem[l][c] = 2'($urandom_range(0, 3));
   endtask

   initial begin
      int tv, td, ti, ns, gap;
      bit seen_done;
      clear_n = 1'b0; start = 1'b0; start2 = 1'b0; out_ready = 1'b1;
      fill_pattern();
      for (int l = 0; l < 4; l++)
         for (int c = 0; c < 4; c++)
            mem2[l][c] = 2'($urandom_range(0, 3));

      repeat (3) @(posedge clk);
      #1;
      tchk("reset_valid", 32'(out_valid), 0);
      tchk("reset_busy", 32'(busy), 0);
      tchk("reset_done", 32'(done), 0);
      tchk("reset_data", 32'(out_data), 0);
      tchk("reset_addr", 32'({addr_line, addr_column}), 0);
      clear_n = 1'b1;
      mon_en  = 1'b1;
      @(posedge clk); #1;

      // Full scan, ready held high.
      run_scan(-1, 0, 0, 0, 0, tv, td, ti, ns);
      tchk("lat_first_valid", 32'(tv), 2);
      tchk("lat_done", 32'(td), 27);
      tchk("lat_idle", 32'(ti), 28);

      // Five cycles of backpressure on the fourth cell.
      run_scan(3, 5, 0, 0, 0, tv, td, ti, ns);
      tchk("bp_stalls", 32'(ns), 5);
      tchk("bp_done", 32'(td), 32);
      tchk("bp_idle", 32'(ti), 33);

      // Stray start pulses mid-scan are ignored.
      run_scan(-1, 0, 0, 1, 0, tv, td, ti, ns);
      tchk("noise_done", 32'(td), 27);

      // start held high: one IDLE cycle, then a second scan.
      start = 1'b1;
      seen_done = 1'b0; gap = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
         else if (seen_done && !busy) gap++;
         else if (seen_done && busy) break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      tchk("held_idle_gap", 32'(gap), 1);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      tchk("held_drain", 32'(busy), 0);
      @(posedge clk); #1;

      // Asynchronous reset while the fifth cell waits in SEND, then rescan.
      run_scan(4, 100, 0, 0, 1, tv, td, ti, ns);
      @(posedge clk); #1;
      run_scan(-1, 0, 1, 0, 0, tv, td, ti, ns);
      tchk("rescan_done", 32'(td), 32'(27 + ns));

      // Random contents, random backpressure, random idle gaps.
      for (int r = 0; r < 6; r++) begin
         fill_random();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         run_scan(-1, 0, 1, 0, 0, tv, td, ti, ns);
         tchk("rand_done", 32'(td), 32'(27 + ns));
         tchk("rand_sb_empty", 32'(sb.size()), 0);
      end

      // 2x4 instance: column wrap with line increment.
      scan2();

      repeat (2) @(posedge clk);
      n_chk  += mon_chk;
      n_fail += mon_fail;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/face_reader.md
Name: face_reader

Overview:
- Read-side scanner for the face RAM (LINES x COLUMNS cells, S_DATA bits each) that the capture path fills.
- On `start`, walks every cell in row-major order and drives the face RAM address lines.
- Absorbs the RAM's registered-address read latency and streams each cell out over a valid/ready handshake toward the downstream consumer (classifier/transmitter).
- Asserts `busy` so the write side keeps `we` low while a scan is in progress.

Parameters:
- LINES, 3, number of face rows
- COLUMNS, 3, number of face columns
- S_DATA, 2, bits per cell
- S_LINE, 2, line address width; LINES <= 2^S_LINE
- S_COLUMN, 2, column address width; COLUMNS <= 2^S_COLUMN

Ports:
- clk  in  1  system clock, all state on rising edge
- clear_n  in  1  reset, asynchronous, active-low
- start  in  1  begin scan; sampled only in IDLE
- addr_line  out  S_LINE  RAM line address
- addr_column  out  S_COLUMN  RAM column address
- q  in  S_DATA  RAM read data; valid one cycle after address is presented
- out_data  out  S_DATA  registered cell value
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when high with out_valid
- out_last  out  1  high with out_valid on final cell (LINES-1, COLUMNS-1)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after final handshake

Behaviour:
- Reset (clear_n low, any time, including mid-scan): state IDLE; addr_line=0, addr_column=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0. No partial output survives reset.
- FSM states: IDLE, FETCH, LOAD, SEND, DONE.
- IDLE -> FETCH on rising edge with start=1. Address is cleared to (0,0).
- FETCH, 1 cycle: address held stable so the RAM registers it at the next edge. -> LOAD.
- LOAD, 1 cycle: q reflects the current address.
  - At the edge: out_data<=q, out_valid<=1.
  - out_last<=1 iff addr == (LINES-1, COLUMNS-1).
  - -> SEND.
- SEND: out_data, out_valid and out_last are held stable until out_ready=1 at an edge.
  - On that edge: out_valid<=0, out_last<=0.
  - If last, -> DONE.
  - Otherwise advance the address and -> FETCH.
  - Address advance: if column == COLUMNS-1, column<=0 and line<=line+1; else column<=column+1. Never exceeds LINES-1/COLUMNS-1 (no wrap into unused codes).
- DONE, 1 cycle: done=1. Address returns to (0,0). -> IDLE.
- Latency:
  - start sampled at edge E0 -> out_valid high after E2 with cell (0,0).
  - Each cell costs 3 cycles with out_ready held high.
  - Full 3x3 scan: final handshake at E27, done high during cycle after E27, busy low after E28.
- out_ready high while out_valid is low has no effect. out_valid never deasserts without a handshake.
- start while busy: ignored, no restart. start held high through DONE triggers a new scan from IDLE on the following edge.
- addr_line/addr_column change only on FETCH entry and DONE, so the RAM address register is never disturbed during LOAD.
- busy=1 from the edge leaving IDLE through the DONE cycle inclusive.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: clear_n low mid-cycle -> all outputs 0 immediately (asynchronous); release -> IDLE, busy=0.
- Full scan, defaults, RAM preloaded row-major 0,1,2,3,0,1,2,3,0, out_ready=1, start pulse at E0:
  - out_data sequence 0,1,2,3,0,1,2,3,0.
  - out_valid first high after E2.
  - out_last only on the 9th cell.
  - done single pulse after E27.
  - addresses visited (0,0)..(2,2) in row-major order.
- Backpressure: out_ready low 5 cycles on cell 4 -> out_data=3, out_valid=1, address stable for all 5 cycles; stream resumes correctly and the total scan is extended by exactly 5 cycles.
- start pulsed at cycles 6 and 15 during a scan -> ignored, sequence unchanged. start held high -> second scan begins the edge after DONE.
- clear_n asserted while in SEND on cell 5 -> out_valid drops at once, state IDLE; a new start rescans from (0,0).
- Parameters LINES=2, COLUMNS=4, S_COLUMN=2 -> 8 cells, column wraps 3->0 with line increment, out_last at (1,3), done after E24.
